// File: rtl/cro_puf_pkg.sv
// Shared types and constants for the CRO PUF measurement engine.
// CRO_PUF_VOTE_EN selects the three-round majority-vote build.
package cro_puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_STOP,
    S_CMP,
    S_DONE
  } state_t;

  localparam int NUM_VOTES   = 3;
  localparam int VOTE_THRESH = 2;

  // Cycles from the accepting edge to resp_valid going high.
  function automatic int puf_latency(int sync_stages, int window, int num_ro);
`ifdef CRO_PUF_VOTE_EN
    return NUM_VOTES * (sync_stages + 2 + window + num_ro / 2) - 1;
`else
    return sync_stages + 2 + window + num_ro / 2;
`endif
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One CRO input: synchroniser, rising-edge detector and saturating edge counter.
module ro_edge_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_in,
  input  logic             clear,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign sat  = &count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      count  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (clear)
        count <= '0;
      else if (cnt_en && rise && !sat)
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cro_puf_core.sv
// CRO bank measurement engine: arm, count over a fixed window, compare pairs 2k/2k+1.
// Define CRO_PUF_VOTE_EN for three measurement rounds with a per-pair majority vote.
module cro_puf_core
  import cro_puf_pkg::*;
#(
  parameter int NUM_RO      = 8,
  parameter int CFG_W       = 3,
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  input  logic [CFG_W-1:0]      challenge_cfg,
  output logic                  ro_en,
  output logic [CFG_W-1:0]      ro_cfg,
  input  logic [NUM_RO-1:0]     ro_in,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [NUM_RO/2-1:0]   response,
  output logic [NUM_RO/2-1:0]   tie,
  output logic                  sat
);

  localparam int NPAIR = NUM_RO / 2;
  localparam int PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int TW    = $clog2(WINDOW + SYNC_STAGES + 1);

  state_t                       state;
  logic [TW-1:0]                timer;
  logic [PW-1:0]                pair;
  logic [NUM_RO-1:0][CNT_W-1:0] count;
  logic [NUM_RO-1:0]            cnt_sat;
  logic                         clear, cnt_en, gt, eq, last_pair;

  assign clear     = (state == S_ARM);
  assign cnt_en    = (state == S_COUNT);
  assign last_pair = (pair == PW'(NPAIR - 1));

  for (genvar g = 0; g < NUM_RO; g++) begin : g_ro
    ro_edge_counter #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .ro_in  (ro_in[g]),
      .clear  (clear),
      .cnt_en (cnt_en),
      .count  (count[g]),
      .sat    (cnt_sat[g])
    );
  end

  // One comparator shared across pairs, steered by the CMP pair index.
  always_comb begin
    gt = 1'b0;
    eq = 1'b0;
    for (int k = 0; k < NPAIR; k++)
      if (pair == PW'(k)) begin
        gt = count[2*k] > count[2*k+1];
        eq = count[2*k] == count[2*k+1];
      end
  end

`ifdef CRO_PUF_VOTE_EN
  logic [1:0]            round;
  logic [NPAIR-1:0][1:0] votes;
  logic [1:0]            vote_sum;
  logic                  last_round;

  assign last_round = (round == 2'(NUM_VOTES - 1));

  always_comb begin
    vote_sum = '0;
    for (int k = 0; k < NPAIR; k++)
      if (pair == PW'(k)) vote_sum = votes[k] + {1'b0, gt};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ready      <= 1'b1;
      ro_en      <= 1'b0;
      ro_cfg     <= '0;
      resp_valid <= 1'b0;
      response   <= '0;
      tie        <= '0;
      sat        <= 1'b0;
      timer      <= '0;
      pair       <= '0;
`ifdef CRO_PUF_VOTE_EN
      round      <= '0;
      votes      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state  <= S_ARM;
          ready  <= 1'b0;
          ro_en  <= 1'b1;
          ro_cfg <= challenge_cfg;
          sat    <= 1'b0;
          timer  <= '0;
`ifdef CRO_PUF_VOTE_EN
          round  <= '0;
          votes  <= '0;
`endif
        end
        S_ARM: begin
          if (timer == TW'(SYNC_STAGES)) begin
            state <= S_COUNT;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_COUNT: begin
          if (timer == TW'(WINDOW - 1)) begin
            ro_en <= 1'b0;
            pair  <= '0;
            timer <= '0;
`ifdef CRO_PUF_VOTE_EN
            // The final round goes straight to CMP; counters freeze outside COUNT anyway.
            state <= last_round ? S_CMP : S_STOP;
`else
            state <= S_STOP;
`endif
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_STOP: begin
          state <= S_CMP;
          pair  <= '0;
        end
        S_CMP: begin
          sat <= sat | (|cnt_sat);
          for (int k = 0; k < NPAIR; k++)
            if (pair == PW'(k)) begin
`ifdef CRO_PUF_VOTE_EN
              votes[k] <= vote_sum;
              tie[k]   <= (round == 2'd0) ? eq : (tie[k] | eq);
              if (last_round) response[k] <= (vote_sum >= 2'(VOTE_THRESH));
`else
              response[k] <= gt;
              tie[k]      <= eq;
`endif
            end
          if (last_pair) begin
`ifdef CRO_PUF_VOTE_EN
            if (last_round) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
            end else begin
              state <= S_ARM;
              ro_en <= 1'b1;
              round <= round + 1'b1;
              timer <= '0;
            end
`else
            state      <= S_DONE;
            resp_valid <= 1'b1;
`endif
          end else begin
            pair <= pair + 1'b1;
          end
        end
        S_DONE: if (resp_ready) begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          ready      <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cro_puf_core.sv
// Randomised bench for cro_puf_core against a timeline/edge-count model of the engine.
module tb_cro_puf_core;
  import cro_puf_pkg::*;

  localparam int NUM_RO      = 8;
  localparam int CFG_W       = 3;
  localparam int CNT_W       = 6;
  localparam int WINDOW      = 256;
  localparam int SYNC_STAGES = 2;
  localparam int NPAIR       = NUM_RO / 2;
  localparam int CMAX        = (1 << CNT_W) - 1;
  localparam int LAT         = puf_latency(SYNC_STAGES, WINDOW, NUM_RO);
`ifdef CRO_PUF_VOTE_EN
  localparam int LAT_LIT = 791;
`else
  localparam int LAT_LIT = 264;
`endif

  logic              clk = 1'b0;
  logic              rst, start, ready, ro_en, resp_valid, resp_ready, sat;
  logic [CFG_W-1:0]  challenge_cfg, ro_cfg;
  logic [NUM_RO-1:0] ro_in;
  logic [NPAIR-1:0]  response, tie;

  cro_puf_core #(
    .NUM_RO(NUM_RO), .CFG_W(CFG_W), .CNT_W(CNT_W), .WINDOW(WINDOW), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .challenge_cfg(challenge_cfg),
    .ro_en(ro_en), .ro_cfg(ro_cfg), .ro_in(ro_in), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .response(response), .tie(tie), .sat(sat)
  );

  always #5 clk = ~clk;

  int per [NUM_RO];
  int ph  [NUM_RO];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Square-wave CRO stand-ins: period per[i], phase ph[i], changing away from the clock edge.
  initial begin
    ro_in = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_RO; i++) ro_in[i] = (((cyc + ph[i]) % per[i]) < per[i] / 2);
    end
  end

  // Model: where the engine is on its fixed timeline and what it must report.
  logic             m_busy;
  int               m_j, m_acc;
  logic [CFG_W-1:0] m_cfg;
  logic [NPAIR-1:0] m_resp, m_tie, p_resp, p_tie, e_resp, e_tie;
  logic             m_sat, p_sat, e_sat;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_j <= 0; m_cfg <= '0;
      m_resp <= '0; m_tie <= '0; m_sat <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1; m_j <= 0; m_acc <= cyc + 1; m_cfg <= challenge_cfg;
        p_resp <= e_resp; p_tie <= e_tie; p_sat <= e_sat;
      end
    end else if (m_j >= LAT) begin
      if (resp_ready) begin
        m_busy <= 1'b0; m_resp <= p_resp; m_tie <= p_tie; m_sat <= p_sat;
      end
    end else begin
      m_j <= m_j + 1;
    end
  end

  // Edge count of a period-p wave over WINDOW cycles lies in [floor, ceil], then saturates.
  function automatic int cnt_lo(int p);
    int n = WINDOW / p;
    return (n > CMAX) ? CMAX : n;
  endfunction
  function automatic int cnt_hi(int p);
    int n = (WINDOW + p - 1) / p;
    return (n > CMAX) ? CMAX : n;
  endfunction
  function automatic bit pair_ok(int pa, int pb);
    return (cnt_lo(pa) > cnt_hi(pb)) || (cnt_hi(pa) < cnt_lo(pb)) ||
           (cnt_lo(pa) == cnt_hi(pa) && cnt_lo(pb) == cnt_hi(pb) && cnt_lo(pa) == cnt_lo(pb));
  endfunction

  task automatic compute_exp();
    e_sat = 1'b0;
    for (int i = 0; i < NUM_RO; i++) if (cnt_lo(per[i]) >= CMAX) e_sat = 1'b1;
    for (int k = 0; k < NPAIR; k++) begin
      int a = 2 * k, b = 2 * k + 1;
      e_resp[k] = 1'b0;
      e_tie[k]  = 1'b0;
      if (per[a] == per[b] && ph[a] == ph[b]) e_tie[k] = 1'b1;
      else if (cnt_lo(per[a]) > cnt_hi(per[b])) e_resp[k] = 1'b1;
      else if (cnt_hi(per[a]) >= cnt_lo(per[b])) e_tie[k] = 1'b1;
    end
  endtask

  task automatic gen_cfg(input int pmin);
    for (int k = 0; k < NPAIR; k++) begin
      int a = 2 * k, b = 2 * k + 1;
      per[a] = $urandom_range(pmin, 16); ph[a] = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        per[b] = per[a]; ph[b] = ph[a];
      end else begin
        for (int t = 0; t < 100; t++) begin
          per[a] = $urandom_range(pmin, 16); per[b] = $urandom_range(pmin, 16);
          ph[b]  = $urandom_range(0, 15);
          if (pair_ok(per[a], per[b])) break;
        end
        if (!pair_ok(per[a], per[b])) begin per[b] = per[a]; ph[b] = ph[a]; end
      end
    end
  endtask

  int   n_vec = 0, n_fail = 0, tcase = 0;
  bit   chk_on = 1'b0;
  logic rv_prev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (chk_on) begin
      chk("ready", int'(ready), int'(!m_busy));
      chk("resp_valid", int'(resp_valid), int'(m_busy && m_j >= LAT));
`ifndef CRO_PUF_VOTE_EN
      chk("ro_en", int'(ro_en), int'(m_busy && m_j <= SYNC_STAGES + WINDOW));
`endif
      chk("ro_cfg", int'(ro_cfg), int'(m_cfg));
      if (!m_busy) begin
        chk("idle_response", int'(response), int'(m_resp));
        chk("idle_tie", int'(tie), int'(m_tie));
        chk("idle_sat", int'(sat), int'(m_sat));
      end else if (m_j >= LAT) begin
        chk("response", int'(response), int'(p_resp));
        chk("tie", int'(tie), int'(p_tie));
        chk("sat", int'(sat), int'(p_sat));
      end
      if (tcase == 9) begin
        chk("rst_ready", int'(ready), 1);
        chk("rst_ro_en", int'(ro_en), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_response", int'(response), 0);
        chk("rst_tie", int'(tie), 0);
        chk("rst_sat", int'(sat), 0);
      end
      if (tcase == 1 && m_busy && m_j <= SYNC_STAGES) chk("arm_cfg", int'(ro_cfg), 5);
      if (tcase == 1 && resp_valid && !rv_prev) begin
        chk("latency", cyc - m_acc, LAT_LIT);
        chk("fast_vs_slow_resp0", int'(response[0]), 1);
        chk("fast_vs_slow_tie0", int'(tie[0]), 0);
        chk("same_wave_tie1", int'(tie[1]), 1);
        chk("same_wave_resp1", int'(response[1]), 0);
        chk("saturated_sat", int'(sat), 1);
      end
      if (tcase == 2 && resp_valid && !rv_prev) chk("slow_sat_clear", int'(sat), 0);
      rv_prev = resp_valid;
    end
  end

  task automatic wait_rv();
    for (int i = 0; i < LAT + 50; i++) begin
      if (resp_valid) break;
      resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (!resp_valid) begin
      $display("FAIL wait_rv: resp_valid never rose within %0d cycles", LAT + 50);
      $fatal(1);
    end
  endtask

  task automatic run_one(input logic [CFG_W-1:0] cfg, input int hold);
    compute_exp();
    challenge_cfg = cfg;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    challenge_cfg = CFG_W'($urandom);
    wait_rv();
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; resp_ready = 1'b0; challenge_cfg = '0;
    for (int i = 0; i < NUM_RO; i++) begin per[i] = 5 + i; ph[i] = 0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: fast vs slow, identical pair, saturating input; held in DONE with start pulses.
    per[0] = 4; per[1] = 8; per[2] = 6; per[3] = 6;
    per[4] = 3; per[5] = 5; per[6] = 7; per[7] = 9;
    for (int i = 0; i < NUM_RO; i++) ph[i] = 0;
    tcase = 1;
    run_one(3'b101, 10);
    tcase = 0;

    // Reset while idle with a non-zero result on the outputs.
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tcase = 9;
    @(negedge clk);
    tcase = 0;
    rst = 1'b0;

    // Slow inputs only: sat must clear.
    gen_cfg(5);
    tcase = 2;
    run_one(CFG_W'($urandom), 2);
    tcase = 0;

    // Reset 100 cycles into the count window, then a clean full measurement.
    gen_cfg(3);
    compute_exp();
    challenge_cfg = CFG_W'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (m_j == SYNC_STAGES + 101) break;
      @(negedge clk);
    end
    if (m_j != SYNC_STAGES + 101) begin
      $display("FAIL mid_count_wait: window cycle 100 not reached");
      $fatal(1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_one(CFG_W'($urandom), 1);

    for (int r = 0; r < 8; r++) begin
      gen_cfg(3);
      run_one(CFG_W'($urandom), $urandom_range(0, 5));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
